// File: rtl/gray_rx_decoder_if.sv
// ----------------------------------------------------------------------------
// gray_rx_decoder_if
//   Bus between a Gray-count source/consumer and the gray_rx_decoder.
//   master : drives Valid/Gray/Clear, observes decoded count and status.
//   slave  : the decoder; observes Valid/Gray/Clear, drives count and status.
//
//   Valid     : Gray sample is valid this cycle
//   Gray      : Gray-coded count (WIDTH bits)
//   Clear     : synchronous clear of error/wrap state, back to IDLE
//   Binary    : registered binary decode of last accepted sample
//   Out_valid : one-cycle pulse, Binary updated this cycle
//   Wrap      : one-cycle pulse, last accepted step was all-ones -> 0
//   Wrap_cnt  : saturating wrap count (CNT_W bits)
//   Step_err  : sticky illegal-step flag
// ----------------------------------------------------------------------------
interface gray_rx_decoder_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
);
    logic             Valid;
    logic [WIDTH-1:0] Gray;
    logic             Clear;
    logic [WIDTH-1:0] Binary;
    logic             Out_valid;
    logic             Wrap;
    logic [CNT_W-1:0] Wrap_cnt;
    logic             Step_err;

    modport master (
        output Valid, Gray, Clear,
        input  Binary, Out_valid, Wrap, Wrap_cnt, Step_err
    );

    modport slave (
        input  Valid, Gray, Clear,
        output Binary, Out_valid, Wrap, Wrap_cnt, Step_err
    );
endinterface

// File: rtl/gray_rx_decoder.sv
// ----------------------------------------------------------------------------
// gray_rx_decoder
//   Receive side of a Gray counter link. Each valid sample is decoded to
//   binary and checked against the previous one: a legal stream only holds
//   or advances by one (mod 2^WIDTH). Wraps all-ones -> 0 are pulsed and
//   counted (saturating); any other step sets a sticky error and disables
//   further checking until Clear.
//
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : gray_rx_decoder_if slave modport (see interface header)
// ----------------------------------------------------------------------------
module gray_rx_decoder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    gray_rx_decoder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no previous sample
        TRACK = 2'd1,   // checking successive samples
        ERROR = 2'd2    // illegal step seen, checking disabled
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] binary_q;     // doubles as the previous accepted sample
    logic             out_valid_q;
    logic             wrap_q;
    logic [CNT_W-1:0] wrap_cnt_q;
    logic             step_err_q;

    logic [WIDTH-1:0] dec_d;
    logic [WIDTH-1:0] next_bin_d;

    // Binary bit i is the XOR of Gray bits i..MSB, i.e. the XOR of all right
    // shifts of the Gray word.
    // NOTE: every variable written in always_comb gets a value on entry so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        dec_d = bus.Gray;
        for (int i = 1; i < WIDTH; i++) begin
            dec_d = dec_d ^ (bus.Gray >> i);
        end
        next_bin_d = binary_q + WIDTH'(1);
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            binary_q    <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_cnt_q  <= '0;
            step_err_q  <= 1'b0;
        end else begin
            // Pulses fall back to 0 unless this edge accepts a sample.
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;

            if (bus.Clear) begin
                // Clear wins over a simultaneous sample; Binary keeps its value.
                state_q    <= IDLE;
                wrap_cnt_q <= '0;
                step_err_q <= 1'b0;
            end else if (bus.Valid) begin
                out_valid_q <= 1'b1;
                binary_q    <= dec_d;
                unique case (state_q)
                    IDLE: state_q <= TRACK;
                    TRACK: begin
                        if (dec_d == binary_q) begin
                            // hold: transmitter not counting
                        end else if (dec_d == next_bin_d) begin
                            if (binary_q == '1) begin
                                wrap_q <= 1'b1;
                                if (wrap_cnt_q != '1) begin
                                    wrap_cnt_q <= wrap_cnt_q + CNT_W'(1);
                                end
                            end
                        end else begin
                            step_err_q <= 1'b1;
                            state_q    <= ERROR;
                        end
                    end
                    ERROR: begin
                        // tracking only; no checks, wrap count frozen
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.Binary    = binary_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Wrap      = wrap_q;
    assign bus.Wrap_cnt  = wrap_cnt_q;
    assign bus.Step_err  = step_err_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// ----------------------------------------------------------------------------
// tb_gray_rx_decoder
//   Two decoders (CNT_W=4 and CNT_W=2) share the same stimulus. A table of
//   directed vectors covers decode, hold, illegal step, Clear and Clear/Valid
//   collision; hand-written sequences cover wrap-count saturation and an
//   asynchronous reset between clock edges.
// ----------------------------------------------------------------------------
module tb_gray_rx_decoder;

    localparam int WIDTH = 3;

    logic             Clk;
    logic             Reset;
    logic             valid;
    logic             clear;
    logic [WIDTH-1:0] gray;

    int n_cmp;
    int n_fail;

    gray_rx_decoder_if #(.WIDTH(WIDTH), .CNT_W(4)) bus4 ();
    gray_rx_decoder_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

    assign bus4.Valid = valid;
    assign bus4.Gray  = gray;
    assign bus4.Clear = clear;
    assign bus2.Valid = valid;
    assign bus2.Gray  = gray;
    assign bus2.Clear = clear;

    gray_rx_decoder #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus4.slave)
    );

    gray_rx_decoder #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus2.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       valid;
        logic       clear;
        logic [2:0] gray;
        int         bin;
        int         ov;
        int         wrap;
        int         cnt4;
        int         cnt2;
        int         err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic c, input logic [2:0] g,
                       input int bin, input int ov, input int wr,
                       input int c4, input int c2, input int er);
        vec_t t;
        t.valid = v; t.clear = c; t.gray = g;
        t.bin = bin; t.ov = ov; t.wrap = wr; t.cnt4 = c4; t.cnt2 = c2; t.err = er;
        vecs.push_back(t);
    endtask

    // Apply one cycle of inputs and sample just after the edge.
    task automatic step(input logic v, input logic c, input logic [2:0] g);
        valid = v;
        clear = c;
        gray  = g;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int bin, input int ov,
                             input int wr, input int c4, input int c2, input int er);
        check({tag, ".Binary"},    int'(bus4.Binary),    bin);
        check({tag, ".Out_valid"}, int'(bus4.Out_valid), ov);
        check({tag, ".Wrap"},      int'(bus4.Wrap),      wr);
        check({tag, ".Wrap_cnt4"}, int'(bus4.Wrap_cnt),  c4);
        check({tag, ".Wrap_cnt2"}, int'(bus2.Wrap_cnt),  c2);
        check({tag, ".Step_err"},  int'(bus4.Step_err),  er);
    endtask

    initial begin
        logic [2:0] seq [8];
        n_cmp  = 0;
        n_fail = 0;
        valid  = 1'b0;
        clear  = 1'b0;
        gray   = '0;
        Reset  = 1'b0;

        // v  c  gray    bin ov wr c4 c2 er
        // full forward sequence with one wrap
        add(1, 0, 3'b000, 0, 1, 0, 0, 0, 0);
        add(1, 0, 3'b001, 1, 1, 0, 0, 0, 0);
        add(1, 0, 3'b011, 2, 1, 0, 0, 0, 0);
        add(1, 0, 3'b010, 3, 1, 0, 0, 0, 0);
        add(1, 0, 3'b110, 4, 1, 0, 0, 0, 0);
        add(1, 0, 3'b111, 5, 1, 0, 0, 0, 0);
        add(1, 0, 3'b101, 6, 1, 0, 0, 0, 0);
        add(1, 0, 3'b100, 7, 1, 0, 0, 0, 0);
        add(1, 0, 3'b000, 0, 1, 1, 1, 1, 0);
        // holds then +1
        add(1, 0, 3'b001, 1, 1, 0, 1, 1, 0);
        add(1, 0, 3'b001, 1, 1, 0, 1, 1, 0);
        add(1, 0, 3'b001, 1, 1, 0, 1, 1, 0);
        add(1, 0, 3'b011, 2, 1, 0, 1, 1, 0);
        // idle cycle, then Clear
        add(0, 0, 3'b000, 2, 0, 0, 1, 1, 0);
        add(0, 1, 3'b000, 2, 0, 0, 0, 0, 0);
        // 1 -> 3 is illegal; ERROR state tracks without checking or wrapping
        add(1, 0, 3'b001, 1, 1, 0, 0, 0, 0);
        add(1, 0, 3'b010, 3, 1, 0, 0, 0, 1);
        add(1, 0, 3'b110, 4, 1, 0, 0, 0, 1);
        add(1, 0, 3'b111, 5, 1, 0, 0, 0, 1);
        add(1, 0, 3'b101, 6, 1, 0, 0, 0, 1);
        add(1, 0, 3'b100, 7, 1, 0, 0, 0, 1);
        add(1, 0, 3'b000, 0, 1, 0, 0, 0, 1);
        // Clear recovers; first sample after it is unchecked
        add(0, 1, 3'b000, 0, 0, 0, 0, 0, 0);
        add(1, 0, 3'b111, 5, 1, 0, 0, 0, 0);
        add(1, 0, 3'b101, 6, 1, 0, 0, 0, 0);
        // Clear beats Valid: sample dropped, Binary holds
        add(1, 1, 3'b011, 6, 0, 0, 0, 0, 0);
        // back in IDLE: 6 -> 2 would be illegal but is a first sample
        add(1, 0, 3'b011, 2, 1, 0, 0, 0, 0);

        repeat (2) @(posedge Clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].clear, vecs[i].gray);
            check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].ov,
                      vecs[i].wrap, vecs[i].cnt4, vecs[i].cnt2, vecs[i].err);
        end

        // Five full wraps: CNT_W=2 saturates at 3, CNT_W=4 keeps counting.
        seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
        seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;
        step(0, 1, 3'b000);
        step(1, 0, 3'b000);
        check("sat.first_wrap", int'(bus4.Wrap), 0);
        for (int w = 1; w <= 5; w++) begin
            for (int k = 1; k < 8; k++) begin
                step(1, 0, seq[k]);
                check($sformatf("sat%0d.bin%0d", w, k), int'(bus4.Binary), k);
            end
            step(1, 0, 3'b000);
            check($sformatf("sat%0d.Wrap4", w), int'(bus4.Wrap), 1);
            check($sformatf("sat%0d.Wrap2", w), int'(bus2.Wrap), 1);
            check($sformatf("sat%0d.cnt4", w), int'(bus4.Wrap_cnt), w);
            check($sformatf("sat%0d.cnt2", w), int'(bus2.Wrap_cnt), (w > 3) ? 3 : w);
        end

        // Asynchronous reset between edges at Binary=5.
        step(0, 1, 3'b000);
        for (int k = 0; k < 6; k++) step(1, 0, seq[k]);
        check("pre_rst.Binary", int'(bus4.Binary), 5);
        check("pre_rst.Out_valid", int'(bus4.Out_valid), 1);
        valid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        #2 Reset = 1'b1;
        step(1, 0, 3'b100);
        check_all("post_rst", 7, 1, 0, 0, 0, 0);
        step(0, 0, 3'b000);
        check("post_rst.idle_ov", int'(bus4.Out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
